// File: rtl/sound_pkg.sv
// Shared types and helpers for the speaker arbiter: FSM state encoding, default widths and a
// lowest-index priority encoder.
package sound_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPlay = 2'd1,
      StGap  = 2'd2
   } state_e;

   localparam int unsigned DefaultDivW = 15;
   localparam int unsigned DefaultDurW = 24;

   // Index of the lowest set bit; 0 when nothing is set (callers qualify with |vec).
   function automatic logic [4:0] lowest_set(input logic [31:0] vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: half-period of div+1 cycles, held at 0 when div is 0.
// Cleared whenever enable is low; load restarts the wave from 0 with a new divider.
module tone_divider
   import sound_pkg::*;
#(
   parameter int unsigned DIV_W = DefaultDivW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             speaker
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             spk_q, spk_d;

   always_comb begin
      cnt_d = cnt_q;
      spk_d = spk_q;
      if (!enable) begin
         cnt_d = '0;
         spk_d = 1'b0;
      end else if (load) begin
         cnt_d = div;
         spk_d = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d = div;
         spk_d = (div != '0) ? ~spk_q : 1'b0;
      end else begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         spk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         spk_q <= spk_d;
      end
   end

   assign speaker = spk_q;

endmodule

// File: rtl/sound_arbiter.sv
// Grants the shared speaker to one requester at a time, plays its tone, then enforces a gap.
// Define SOUND_ARBITER_PREEMPT_EN to let a higher-priority request cut the current tone short.
module sound_arbiter
   import sound_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DIV_W      = DefaultDivW,
   parameter int unsigned DUR_W      = DefaultDurW,
   parameter int unsigned GAP_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*DIV_W-1:0] req_div,
   input  logic [NUM_REQ*DUR_W-1:0] req_dur,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic                     speaker
);

   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GapW-1:0]    GapLoad = GapW'(GAP_CYCLES - 1);
   localparam logic [NUM_REQ-1:0] OneReq  = NUM_REQ'(1);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] owner_q, owner_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
   logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;

   logic [4:0]         sel_idx;
   logic [NUM_REQ-1:0] sel_oh;
   logic [DIV_W-1:0]   sel_div;
   logic [DUR_W-1:0]   sel_dur;
   logic               start;
   logic               preempt;
   logic               owner_req;

   assign sel_idx   = lowest_set(32'(req));
   assign sel_oh    = OneReq << sel_idx;
   assign owner_req = |(req & owner_q);

`ifdef SOUND_ARBITER_PREEMPT_EN
   // owner_q - 1 masks every index below the one-hot owner.
   assign preempt = |(req & (owner_q - OneReq));
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      sel_div = '0;
      sel_dur = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_oh[i]) begin
            sel_div = req_div[i*DIV_W +: DIV_W];
            sel_dur = req_dur[i*DUR_W +: DUR_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      div_d     = div_q;
      dur_cnt_d = dur_cnt_q;
      gap_cnt_d = gap_cnt_q;
      done_d    = '0;
      start     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|req) start = 1'b1;
         end
         StPlay: begin
            if (preempt) begin
               start = 1'b1;
            end else if (!owner_req) begin
               state_d   = StGap;
               gap_cnt_d = GapLoad;
            end else if (dur_cnt_q == '0) begin
               state_d   = StGap;
               gap_cnt_d = GapLoad;
               done_d    = owner_q;
            end else begin
               dur_cnt_d = dur_cnt_q - DUR_W'(1);
            end
         end
         StGap: begin
            if (gap_cnt_q == '0) state_d = StIdle;
            else gap_cnt_d = gap_cnt_q - GapW'(1);
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         state_d = StPlay;
         owner_d = sel_oh;
         div_d   = sel_div;
         // A zero duration still plays for one cycle.
         dur_cnt_d = (sel_dur == '0) ? '0 : sel_dur - DUR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         div_q     <= '0;
         dur_cnt_q <= '0;
         gap_cnt_q <= '0;
         done_q    <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         div_q     <= div_d;
         dur_cnt_q <= dur_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         done_q    <= done_d;
      end
   end

   tone_divider #(
      .DIV_W (DIV_W)
   ) u_tone_divider (
      .clk     (clk),
      .rst     (rst),
      .enable  (state_d == StPlay),
      .load    (start),
      .div     (div_d),
      .speaker (speaker)
   );

   assign grant = (state_q == StPlay) ? owner_q : '0;
   assign done  = done_q;
   assign busy  = (state_q != StIdle);

endmodule
